// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and small helpers for the VGA sync path.
// The optional frame counter of vga_sync_gen is enabled with VGA_FRAME_CNT_EN.
package vga_timing_pkg;

    localparam int COORD_W       = 10;

    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam int VGA_CLK_DIV   = 4;

    localparam int VGA_H_TOTAL   = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL   = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int VGA_HS_START  = VGA_H_DISPLAY + VGA_H_FRONT;
    localparam int VGA_HS_END    = VGA_HS_START + VGA_H_SYNC - 1;
    localparam int VGA_VS_START  = VGA_V_DISPLAY + VGA_V_FRONT;
    localparam int VGA_VS_END    = VGA_VS_START + VGA_V_SYNC - 1;

    // Inclusive window test used for the sync pulse decodes.
    function automatic logic in_window(
        input logic [COORD_W-1:0] v,
        input logic [COORD_W-1:0] lo,
        input logic [COORD_W-1:0] hi
    );
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_pix_tick.sv
// Pixel-enable divider: registered one-clk strobe every CLK_DIV clocks.
module vga_pix_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] div_nxt_s;
    logic             tick_r;

    // Next divider value, wrapping after CLK_DIV-1.
    always_comb begin
        div_nxt_s = div_r;
        if (div_r == DIV_W'(CLK_DIV - 1)) begin
            div_nxt_s = '0;
        end else begin
            div_nxt_s = div_r + DIV_W'(1);
        end
    end

    // Strobe is loaded from the value div takes on this edge, so it tracks div == CLK_DIV-1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_r  <= '0;
            tick_r <= 1'b0;
        end else begin
            div_r  <= div_nxt_s;
            tick_r <= (div_nxt_s == DIV_W'(CLK_DIV - 1));
        end
    end

    assign p_tick = tick_r;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel counters, registered sync/video_on decode, frame pulse.
// Define VGA_FRAME_CNT_EN to add the 8-bit frame_cnt output.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = VGA_H_DISPLAY,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_DISPLAY = VGA_V_DISPLAY,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK,
    parameter int CLK_DIV   = VGA_CLK_DIV
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               p_tick,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0]         frame_cnt
`endif
);

    localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_DISPLAY + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_DISPLAY + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    logic               tick_s;
    logic               wrap_s;
    logic [COORD_W-1:0] x_r;
    logic [COORD_W-1:0] y_r;
    logic [COORD_W-1:0] x_nxt_s;
    logic [COORD_W-1:0] y_nxt_s;
    logic               hsync_r;
    logic               vsync_r;
    logic               video_on_r;
    logic               frame_start_r;

    vga_pix_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_tick (
        .clk     (clk_100MHz),
        .reset   (reset),
        .p_tick  (tick_s)
    );

    // Next pixel position; wrap_s marks the (H_TOTAL-1, V_TOTAL-1) -> (0,0) step.
    always_comb begin
        x_nxt_s = x_r;
        y_nxt_s = y_r;
        wrap_s  = 1'b0;
        if (tick_s) begin
            if (x_r == COORD_W'(H_TOTAL - 1)) begin
                x_nxt_s = '0;
                if (y_r == COORD_W'(V_TOTAL - 1)) begin
                    y_nxt_s = '0;
                    wrap_s  = 1'b1;
                end else begin
                    y_nxt_s = y_r + COORD_W'(1);
                end
            end else begin
                x_nxt_s = x_r + COORD_W'(1);
            end
        end else begin
            x_nxt_s = x_r;
        end
    end

    // Decode is taken from the next position so outputs line up with x/y in the same cycle.
    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            x_r           <= '0;
            y_r           <= '0;
            hsync_r       <= 1'b1;
            vsync_r       <= 1'b1;
            video_on_r    <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            x_r           <= x_nxt_s;
            y_r           <= y_nxt_s;
            hsync_r       <= ~in_window(x_nxt_s, COORD_W'(HS_START), COORD_W'(HS_END));
            vsync_r       <= ~in_window(y_nxt_s, COORD_W'(VS_START), COORD_W'(VS_END));
            video_on_r    <= (x_nxt_s < COORD_W'(H_DISPLAY)) && (y_nxt_s < COORD_W'(V_DISPLAY));
            frame_start_r <= wrap_s;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_r;

    // Frames completed since reset, wrapping naturally at 8 bits.
    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            frame_cnt_r <= 8'd0;
        end else if (wrap_s) begin
            frame_cnt_r <= frame_cnt_r + 8'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign frame_cnt = frame_cnt_r;
`endif

    assign x           = x_r;
    assign y           = y_r;
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign video_on    = video_on_r;
    assign p_tick      = tick_s;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default 640x480 instance plus a tiny-frame instance, both
// compared every cycle against a model derived from the clock count since reset.
module tb_vga_sync_gen;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    logic       d_hs, d_vs, d_von, d_tick, d_fs;
    logic [9:0] d_x, d_y;
    logic       s_hs, s_vs, s_von, s_tick, s_fs;
    logic [9:0] s_x, s_y;
    logic [7:0] d_fc, s_fc;

`ifndef VGA_FRAME_CNT_EN
    assign d_fc = 8'd0;
    assign s_fc = 8'd0;
`endif

    vga_sync_gen dut_def (
        .clk_100MHz  (clk),
        .reset       (reset),
        .hsync       (d_hs),
        .vsync       (d_vs),
        .video_on    (d_von),
        .p_tick      (d_tick),
        .x           (d_x),
        .y           (d_y),
        .frame_start (d_fs)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt   (d_fc)
`endif
    );

    vga_sync_gen #(
        .H_DISPLAY (4), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
        .V_DISPLAY (2), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
        .CLK_DIV   (4)
    ) dut_small (
        .clk_100MHz  (clk),
        .reset       (reset),
        .hsync       (s_hs),
        .vsync       (s_vs),
        .video_on    (s_von),
        .p_tick      (s_tick),
        .x           (s_x),
        .y           (s_y),
        .frame_start (s_fs)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt   (s_fc)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: after k released edges, pixel index is k/div; everything else follows arithmetically.
    task automatic check_dut(
        input string n, input longint k,
        input int hd, input int hf, input int hs, input int hb,
        input int vd, input int vf, input int vs, input int vb, input int dv,
        input logic [9:0] ox, input logic [9:0] oy,
        input logic ohs, input logic ovs, input logic ovon,
        input logic otick, input logic ofs, input logic [7:0] ofc
    );
        longint ht, vt, p, d, ex, ey, frames;
        logic run, e_tick, e_von, e_hs, e_vs, e_fs;
        ht = hd + hf + hs + hb;
        vt = vd + vf + vs + vb;
        p  = k / dv;
        d  = k % dv;
        ex = p % ht;
        ey = (p / ht) % vt;
        frames = p / (ht * vt);
        run    = (k > 0);
        e_tick = run && (d == dv - 1);
        e_von  = run && (ex < hd) && (ey < vd);
        e_hs   = !(run && (ex >= hd + hf) && (ex < hd + hf + hs));
        e_vs   = !(run && (ey >= vd + vf) && (ey < vd + vf + vs));
        e_fs   = run && (d == 0) && (p > 0) && ((p % (ht * vt)) == 0);
        check($sformatf("%s.x k=%0d", n, k), ox, ex);
        check($sformatf("%s.y k=%0d", n, k), oy, ey);
        check($sformatf("%s.hsync k=%0d", n, k), ohs, e_hs);
        check($sformatf("%s.vsync k=%0d", n, k), ovs, e_vs);
        check($sformatf("%s.video_on k=%0d", n, k), ovon, e_von);
        check($sformatf("%s.p_tick k=%0d", n, k), otick, e_tick);
        check($sformatf("%s.frame_start k=%0d", n, k), ofs, e_fs);
`ifdef VGA_FRAME_CNT_EN
        check($sformatf("%s.frame_cnt k=%0d", n, k), ofc, frames % 256);
`endif
    endtask

    longint k_r    = 0;
    bit     seen_r = 1'b0;

    // Count edges since the last edge that saw reset low.
    always @(posedge clk) begin
        if (!reset) k_r <= 0;
        else        k_r <= k_r + 1;
        seen_r <= 1'b1;
    end

    // Compare both instances away from the active edge.
    always @(negedge clk) begin
        if (seen_r) begin
            check_dut("def", k_r, 640, 16, 96, 48, 480, 10, 2, 33, 4,
                      d_x, d_y, d_hs, d_vs, d_von, d_tick, d_fs, d_fc);
            check_dut("small", k_r, 4, 1, 2, 1, 2, 1, 1, 1, 4,
                      s_x, s_y, s_hs, s_vs, s_von, s_tick, s_fs, s_fc);
        end
    end

    initial begin
        reset = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;

        // Mid-pixel reset with the default instance at x=320 (div=1).
        repeat (1281) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Randomly placed reset pulses of 1..3 clocks.
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 999) == 0) begin
                reset = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                reset = 1'b1;
            end
        end

        // Long free run: many default lines, and >256 tiny frames for the frame counter wrap.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (42000) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
